rns_pipe_comparator: RTL and testbench
======================================

# rns_pipe_comparator

Parametrised, pipelined magnitude comparator for the RNS datapath. It generalises the fixed 12-bit combinational greater-or-equal compare to any operand width, and resolves the compare MSB-first in CHUNK-bit slices, one pipeline stage per slice. It selects one of six relations per transaction, supports signed or unsigned operands, and uses a valid/ready handshake with a sideband tag. It sits ahead of modular-correction and residue-to-binary stages, where a wide single-cycle compare limits Fmax.

## Interface
- WIDTH, 12: operand width in bits, ≥ 2.
- CHUNK, 6: bits resolved per stage, 1..WIDTH; STAGES = ceil(WIDTH/CHUNK).
- TAG_W, 4: sideband tag width, ≥ 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block accepts this cycle.
- a  in  WIDTH  left operand.
- b  in  WIDTH  right operand.
- mode  in  3  relation: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6/7 reserved.
- signed_en  in  1  1 = two's-complement compare, 0 = unsigned.
- tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  1  relation true for (a, b).
- gt, eq, lt  out  1 each  raw ordering flags; exactly one is high when out_valid = 1.
- tag_out  out  TAG_W  tag of the current result.

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Stall rule: advance = !out_valid | out_ready.
  - in_ready = advance.
  - When advance is 0, every stage register holds.
  - When advance is 1, every stage shifts by one slot and bubbles propagate as valid = 0.
- Signed handling: when signed_en = 1, stage 0 inverts a[WIDTH-1] and b[WIDTH-1] before comparing. Unsigned compare of the biased values then equals the signed order.
- Slice k covers bits [WIDTH-1-k*CHUNK -: CHUNK] for k < STAGES-1. The last slice takes the remaining WIDTH-(STAGES-1)*CHUNK LSBs, which may be fewer than CHUNK.
- Per-stage state is {valid, eq_sofar, gt_sofar, remaining operand bits, mode, tag}. Stage k:
  - If eq_sofar = 1: gt_sofar = (slice_a > slice_b) and eq_sofar = (slice_a == slice_b).
  - Otherwise gt_sofar and eq_sofar hold their values.
  - Bits already consumed are dropped and not carried forward.
- Output decode from the final stage:
  - gt = gt_sofar & !eq_sofar, eq = eq_sofar, lt = !gt_sofar & !eq_sofar.
  - result = mode-selected relation; reserved modes give result = 0, with flags still valid.
- mode, signed_en and tag are sampled at input transfer and travel with the data. There is no global mode register.

## Timing
- Reset (asynchronous assert, synchronous-safe release): all stage valids = 0, so out_valid = 0. result, gt, eq, lt = 0 and tag_out = 0. in_ready = 1 from the first cycle after reset.
- Latency: a transfer in at edge N gives out_valid = 1 after edge N+STAGES-1 when there is no stall (WIDTH 12 / CHUNK 6: 2 cycles). STAGES = 1 gives one registered cycle.
- Throughput: one compare per cycle while out_ready = 1.
- out_valid held with out_ready = 0: result, flags and tag_out stay stable, in_ready = 0, and no upstream data is lost or overwritten.
- Simultaneous out transfer and in transfer in the same cycle is legal and keeps full throughput.
- Reset asserted mid-operation: all in-flight results are discarded and none appear after release.
- in_valid = 0 with advance = 1 inserts a bubble. Results always leave in acceptance order.

## Structure
- Shared package rns_cmp_pkg:
  - Mode codes CMP_EQ..CMP_GE and the reserved range.
  - Function to compute STAGES from WIDTH and CHUNK.
  - Stage state struct {valid, eq, gt, mode, signed, tag}.
- Sub-module rns_cmp_stage: one slice compare plus its register, parametrised by slice width. The top level generates STAGES instances and the output decode.

## Test plan
- Unsigned, WIDTH 12 / CHUNK 6, a=0x800, b=0x7FF, mode GE -> result 1, gt 1, out_valid after 2 cycles, tag echoed.
- Signed_en=1, a=0x800 (-2048), b=0x001, mode LT -> result 1, lt 1. The same operands with signed_en=0 -> lt 0, gt 1.
- Decision in the last slice only: a=0x3C5, b=0x3C6. The six modes EQ..GE in consecutive cycles give results 0,1,1,1,0,0; mode 7 gives result 0 with lt 1.
- Backpressure: stream 8 compares, hold out_ready=0 for 3 cycles mid-stream -> in_ready drops, the held output stays stable, all 8 results arrive in order with correct tags.
- WIDTH 13 / CHUNK 4 (partial 1-bit LSB slice), a=0x1FFF, b=0x1FFE -> gt 1 after 4 cycles. Follow with 10k random operands and modes checked against a reference model.
- Assert rst_n low with 2 compares in flight -> out_valid 0 immediately, no stale result after release.

Source files
------------

// File: rtl/rns_cmp_pkg.sv
// Shared definitions for the pipelined RNS magnitude comparator.
// Mode codes, stage-state bundle and stage-count helper.
package rns_cmp_pkg;

   localparam logic [2:0] CMP_EQ   = 3'd0;
   localparam logic [2:0] CMP_NE   = 3'd1;
   localparam logic [2:0] CMP_LT   = 3'd2;
   localparam logic [2:0] CMP_LE   = 3'd3;
   localparam logic [2:0] CMP_GT   = 3'd4;
   localparam logic [2:0] CMP_GE   = 3'd5;
   localparam logic [2:0] CMP_RSV0 = 3'd6;
   localparam logic [2:0] CMP_RSV1 = 3'd7;

   // Tag rides beside this bundle so its width can stay a parameter.
   typedef struct packed {
      logic       valid;
      logic       eq;
      logic       gt;
      logic [2:0] mode;
      logic       sgn;
   } cmp_st_t;

   function automatic int n_stages(input int w, input int c);
      return (w + c - 1) / c;
   endfunction

endpackage

// File: rtl/rns_cmp_stage.sv
// One MSB-first slice of the compare plus its pipeline register.
// Consumed bits are dropped; only the lower remainder moves on.
module rns_cmp_stage
   import rns_cmp_pkg::*;
#(
   parameter  int IN_W  = 12,
   parameter  int SW    = 6,
   parameter  int TAG_W = 4,
   localparam int OUT_W = IN_W - SW,
   localparam int OW    = (OUT_W > 0) ? OUT_W : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   input  cmp_st_t          st_in,
   input  logic [IN_W-1:0]  a_in,
   input  logic [IN_W-1:0]  b_in,
   input  logic [TAG_W-1:0] tag_in,
   output cmp_st_t          st_q,
   output logic [OW-1:0]    a_q,
   output logic [OW-1:0]    b_q,
   output logic [TAG_W-1:0] tag_q
);

   logic [SW-1:0] sa;
   logic [SW-1:0] sb;
   logic [OW-1:0] ra;
   logic [OW-1:0] rb;
   cmp_st_t       st_nx;

   assign sa = a_in[IN_W-1 -: SW];
   assign sb = b_in[IN_W-1 -: SW];

   if (OUT_W > 0) begin : g_rem
      assign ra = a_in[OW-1:0];
      assign rb = b_in[OW-1:0];
   end else begin : g_last
      assign ra = '0;
      assign rb = '0;
   end

   // Resolve this slice only while all higher slices were equal.
   always_comb begin
      st_nx = st_in;
      if (st_in.eq) begin
         st_nx.gt = (sa > sb);
         st_nx.eq = (sa == sb);
      end
   end

   // Stage register; holds the whole slot while the pipe is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         tag_q <= '0;
      end else if (adv) begin
         st_q  <= st_nx;
         a_q   <= ra;
         b_q   <= rb;
         tag_q <= tag_in;
      end
   end

endmodule

// File: rtl/rns_pipe_comparator.sv
// Parametrised pipelined magnitude comparator, CHUNK bits per stage.
// Signed operands are biased at the input so all slices compare unsigned.
module rns_pipe_comparator
   import rns_cmp_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int CHUNK = 6,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       mode,
   input  logic             signed_en,
   input  logic [TAG_W-1:0] tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             result,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic [TAG_W-1:0] tag_out
);

   localparam int STAGES = n_stages(WIDTH, CHUNK);

   logic             adv;
   cmp_st_t          st0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   cmp_st_t          fin;
   logic [TAG_W-1:0] fin_tag;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Build the stage-0 slot; flipping the sign bits maps signed order onto unsigned.
   always_comb begin
      st0           = '0;
      st0.valid     = in_valid;
      st0.eq        = 1'b1;
      st0.mode      = mode;
      st0.sgn       = signed_en;
      a0            = a;
      b0            = b;
      a0[WIDTH-1]   = a[WIDTH-1] ^ signed_en;
      b0[WIDTH-1]   = b[WIDTH-1] ^ signed_en;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int IN_W = WIDTH - k * CHUNK;
      localparam int SW   = (k < STAGES - 1) ? CHUNK : IN_W;
      localparam int OW   = (IN_W > SW) ? IN_W - SW : 1;

      cmp_st_t          st_in;
      cmp_st_t          st_q;
      logic [IN_W-1:0]  a_in;
      logic [IN_W-1:0]  b_in;
      logic [OW-1:0]    a_q;
      logic [OW-1:0]    b_q;
      logic [TAG_W-1:0] tag_in;
      logic [TAG_W-1:0] tag_q;

      if (k == 0) begin : g_first
         assign st_in  = st0;
         assign a_in   = a0;
         assign b_in   = b0;
         assign tag_in = tag;
      end else begin : g_next
         assign st_in  = g_stg[k-1].st_q;
         assign a_in   = g_stg[k-1].a_q;
         assign b_in   = g_stg[k-1].b_q;
         assign tag_in = g_stg[k-1].tag_q;
      end

      rns_cmp_stage #(
         .IN_W  (IN_W),
         .SW    (SW),
         .TAG_W (TAG_W)
      ) u_stage (
         .clk    (clk),
         .rst_n  (rst_n),
         .adv    (adv),
         .st_in  (st_in),
         .a_in   (a_in),
         .b_in   (b_in),
         .tag_in (tag_in),
         .st_q   (st_q),
         .a_q    (a_q),
         .b_q    (b_q),
         .tag_q  (tag_q)
      );
   end

   assign fin     = g_stg[STAGES-1].st_q;
   assign fin_tag = g_stg[STAGES-1].tag_q;

   // Output decode; everything reads zero while no result is held.
   always_comb begin
      out_valid = fin.valid;
      gt        = fin.valid & fin.gt & ~fin.eq;
      eq        = fin.valid & fin.eq;
      lt        = fin.valid & ~fin.gt & ~fin.eq;
      tag_out   = fin.valid ? fin_tag : '0;
      case (fin.mode)
         CMP_EQ:  result = eq;
         CMP_NE:  result = gt | lt;
         CMP_LT:  result = lt;
         CMP_LE:  result = lt | eq;
         CMP_GT:  result = gt;
         CMP_GE:  result = gt | eq;
         default: result = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_rns_pipe_comparator.sv
// Scoreboard bench for rns_pipe_comparator (12/6 and 13/4 instances).
// Expected {result,gt,eq,lt,tag} queued at input transfer, checked at output transfer.
module tb_rns_pipe_comparator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        iv, ir, ov, ordy, res, gt, eq, lt, se;
   logic [11:0] a, b;
   logic [2:0]  md;
   logic [3:0]  tg, tgo;

   logic        iv13, ir13, ov13, ordy13, res13, gt13, eq13, lt13, se13;
   logic [12:0] a13, b13;
   logic [2:0]  md13;
   logic [3:0]  tg13, tgo13;

   int errors = 0;
   int checks = 0;

   logic [7:0] q12[$];
   logic [7:0] q13[$];

   rns_pipe_comparator #(.WIDTH(12), .CHUNK(6), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
      .a(a), .b(b), .mode(md), .signed_en(se), .tag(tg),
      .out_valid(ov), .out_ready(ordy), .result(res),
      .gt(gt), .eq(eq), .lt(lt), .tag_out(tgo)
   );

   rns_pipe_comparator #(.WIDTH(13), .CHUNK(4), .TAG_W(4)) dut13 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv13), .in_ready(ir13),
      .a(a13), .b(b13), .mode(md13), .signed_en(se13), .tag(tg13),
      .out_valid(ov13), .out_ready(ordy13), .result(res13),
      .gt(gt13), .eq(eq13), .lt(lt13), .tag_out(tgo13)
   );

   function automatic logic [3:0] ref_cmp(input logic [15:0] x, input logic [15:0] y,
                                          input int w, input logic [2:0] m, input logic s);
      longint vx, vy;
      logic   r, g, e, l;
      vx = longint'(x);
      vy = longint'(y);
      if (s && x[w-1]) vx = vx - (longint'(1) << w);
      if (s && y[w-1]) vy = vy - (longint'(1) << w);
      g = vx > vy;
      e = vx == vy;
      l = vx < vy;
      case (m)
         3'd0:    r = e;
         3'd1:    r = !e;
         3'd2:    r = l;
         3'd3:    r = l | e;
         3'd4:    r = g;
         3'd5:    r = g | e;
         default: r = 1'b0;
      endcase
      return {r, g, e, l};
   endfunction

   always @(negedge clk) begin
      if (rst_n && ov) begin
         if (q12.size() == 0) begin
            checks++; errors++;
            $display("FAIL mon12 unexpected result tag=%0h with empty scoreboard", tgo);
         end else if (ordy) begin
            logic [7:0] e12;
            e12 = q12.pop_front();
            checks++;
            if ({res, gt, eq, lt, tgo} !== e12) begin
               errors++;
               $display("FAIL mon12 got r/g/e/l/tag=%b_%h expected %b_%h",
                        {res, gt, eq, lt}, tgo, e12[7:4], e12[3:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov13) begin
         if (q13.size() == 0) begin
            checks++; errors++;
            $display("FAIL mon13 unexpected result tag=%0h with empty scoreboard", tgo13);
         end else if (ordy13) begin
            logic [7:0] e13;
            e13 = q13.pop_front();
            checks++;
            if ({res13, gt13, eq13, lt13, tgo13} !== e13) begin
               errors++;
               $display("FAIL mon13 got r/g/e/l/tag=%b_%h expected %b_%h",
                        {res13, gt13, eq13, lt13}, tgo13, e13[7:4], e13[3:0]);
            end
         end
      end
   end

   task automatic send12(input logic [11:0] xa, input logic [11:0] xb, input logic [2:0] m,
                         input logic s, input logic [3:0] t, input logic [3:0] e);
      int n;
      n = 0;
      a = xa; b = xb; md = m; se = s; tg = t; iv = 1'b1;
      @(negedge clk);
      while (!ir && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ir) begin
         checks++; errors++;
         $display("FAIL send12 in_ready timeout got 0 expected 1");
      end else begin
         q12.push_back({e, t});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send13(input logic [12:0] xa, input logic [12:0] xb, input logic [2:0] m,
                         input logic s, input logic [3:0] t, input logic [3:0] e);
      int n;
      n = 0;
      a13 = xa; b13 = xb; md13 = m; se13 = s; tg13 = t; iv13 = 1'b1;
      @(negedge clk);
      while (!ir13 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ir13) begin
         checks++; errors++;
         $display("FAIL send13 in_ready timeout got 0 expected 1");
      end else begin
         q13.push_back({e, t});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      iv = 1'b0;
      iv13 = 1'b0;
      while ((q12.size() != 0 || q13.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (q12.size() != 0 || q13.size() != 0) begin
         errors++;
         $display("FAIL drain pending got %0d/%0d expected 0/0", q12.size(), q13.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      iv = 1'b0; ordy = 1'b1; a = '0; b = '0; md = '0; se = 1'b0; tg = '0;
      iv13 = 1'b0; ordy13 = 1'b1; a13 = '0; b13 = '0; md13 = '0; se13 = 1'b0; tg13 = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ov, res, gt, eq, lt, tgo, ov13, tgo13} !== 15'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b expected 0", {ov, res, gt, eq, lt, tgo, ov13, tgo13});
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({ir, ov, ir13, ov13} !== 4'b1010) begin
         errors++;
         $display("FAIL reset_ready got %b expected 1010", {ir, ov, ir13, ov13});
      end
   endtask

   task automatic test_ge_latency();
      int n;
      send12(12'h800, 12'h7FF, 3'd5, 1'b0, 4'h5, 4'b1100);
      iv = 1'b0;
      n = 0;
      while (n < 10) begin
         @(negedge clk);
         n++;
         if (ov) break;
      end
      checks++;
      if (n != 2) begin
         errors++;
         $display("FAIL ge_latency got %0d expected 2", n);
      end
      drain();
   endtask

   task automatic test_signed();
      send12(12'h800, 12'h001, 3'd2, 1'b1, 4'h6, 4'b1001);
      send12(12'h800, 12'h001, 3'd2, 1'b0, 4'h7, 4'b0100);
      drain();
   endtask

   task automatic test_last_slice();
      logic [5:0] rexp;
      rexp = 6'b001110;
      for (int m = 0; m < 6; m++)
         send12(12'h3C5, 12'h3C6, 3'(m), 1'b0, 4'(m), {rexp[m], 3'b001});
      send12(12'h3C5, 12'h3C6, 3'd7, 1'b0, 4'h7, 4'b0001);
      drain();
   endtask

   task automatic test_back_to_back();
      logic [8:0] snap;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic [11:0] xa, xb;
               logic [2:0]  m;
               logic        s;
               xa = 12'($urandom_range(0, 4095));
               xb = (i % 3 == 0) ? xa : 12'($urandom_range(0, 4095));
               m  = 3'($urandom_range(0, 7));
               s  = 1'($urandom_range(0, 1));
               send12(xa, xb, m, s, 4'(i), ref_cmp({4'b0, xa}, {4'b0, xb}, 12, m, s));
            end
            iv = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            ordy = 1'b0;
            @(negedge clk);
            snap = {ov, res, gt, eq, lt, tgo};
            checks++;
            if ({ov, ir} !== 2'b10) begin
               errors++;
               $display("FAIL stall_entry got ov/ir=%b expected 10", {ov, ir});
            end
            repeat (2) begin
               @(negedge clk);
               checks++;
               if ({ov, res, gt, eq, lt, tgo, ir} !== {snap, 1'b0}) begin
                  errors++;
                  $display("FAIL stall_hold got %b expected %b",
                           {ov, res, gt, eq, lt, tgo, ir}, {snap, 1'b0});
               end
            end
            @(posedge clk);
            #1;
            ordy = 1'b1;
         end
      join
      drain();
   endtask

   task automatic test_w13();
      int  n;
      bit  done;
      send13(13'h1FFF, 13'h1FFE, 3'd4, 1'b0, 4'h9, 4'b1100);
      iv13 = 1'b0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (ov13) break;
      end
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL w13_latency got %0d expected 4", n);
      end
      drain();
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               logic [12:0] xa, xb;
               logic [2:0]  m;
               logic        s;
               xa = 13'($urandom_range(0, 8191));
               xb = 13'($urandom_range(0, 8191));
               if ($urandom_range(0, 3) == 0) xb = xa ^ 13'(1 << $urandom_range(0, 3));
               if ($urandom_range(0, 7) == 0) xb = xa;
               m  = 3'($urandom_range(0, 7));
               s  = 1'($urandom_range(0, 1));
               send13(xa, xb, m, s, 4'(i), ref_cmp({3'b0, xa}, {3'b0, xb}, 13, m, s));
            end
            iv13 = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               ordy13 = ($urandom_range(0, 3) != 0);
            end
            ordy13 = 1'b1;
         end
      join
      drain();
   endtask

   task automatic test_reset_inflight();
      send12(12'h123, 12'h122, 3'd4, 1'b0, 4'hA, 4'b1100);
      send12(12'h010, 12'h020, 3'd2, 1'b0, 4'hB, 4'b1001);
      iv = 1'b0;
      rst_n = 1'b0;
      #1;
      q12.delete();
      checks++;
      if ({ov, res, gt, eq, lt, tgo} !== 9'b0) begin
         errors++;
         $display("FAIL reset_inflight got %b expected 0", {ov, res, gt, eq, lt, tgo});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (ov !== 1'b0) begin
            errors++;
            $display("FAIL reset_stale got out_valid=%b expected 0", ov);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ge_latency();
      test_signed();
      test_last_slice();
      test_back_to_back();
      test_w13();
      test_reset_inflight();
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
